uart_tx_core: RTL and testbench

- UART transmit serializer that sits directly downstream of baud_generator and consumes its `tick` output.
- Accepts a parallel byte on a start strobe and shifts out a frame LSB-first on `tx`: start bit, data, optional parity, then 1 or 2 stop bits.
- Each bit lasts OVS ticks.
- Provides busy/done handshake toward the APB register front-end.

---
 rtl/uart_tx_core.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// UART transmit serializer driven by baud_generator ticks: start, DATA_W data bits LSB-first, optional parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to add the parity_odd input and a parity bit after the data bits.
module uart_tx_core #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              stop_2,
`ifdef UART_TX_PARITY_EN
  input  logic              parity_odd,
`endif
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int CNT_W = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                stop2_q, stop2_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_end;
`ifdef UART_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  assign bit_end = tick && (cnt_q == CNT_W'(OVS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    stop2_d = stop2_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    // The tick counter only runs inside a frame, so an accept-cycle tick is never counted.
    if (state_q != S_IDLE && tick) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          shift_d = tx_data;
          stop2_d = stop_2;
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx_data) ^ parity_odd;
`endif
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          // bit_q counts stop bits already sent; a second one is needed only with stop2_q.
          if (stop2_q && bit_q == '0) begin
            bit_d = BIT_W'(1);
          end else begin
            bit_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Randomized self-checking bench for uart_tx_core against a frame-level reference model (bit list indexed by tick count).
// Define UART_TX_PARITY_EN for both files to exercise the parity build.
module tb_uart_tx_core;

  localparam int DATA_W = 8;
  localparam int OVS    = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS  = 1;
`else
  localparam int PBITS  = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              tick;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              stop_2;
  logic              tx;
  logic              busy;
  logic              tx_done;
`ifdef UART_TX_PARITY_EN
  logic              parity_odd;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is a list of bits, each lasting OVS counted ticks.
  bit m_in_frame;
  bit m_done;
  int m_n;
  int m_total;
  bit m_bits[$];

  uart_tx_core #(.DATA_W(DATA_W), .OVS(OVS)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .stop_2     (stop_2),
`ifdef UART_TX_PARITY_EN
    .parity_odd (parity_odd),
`endif
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void modelAccept(input logic [DATA_W-1:0] d, input logic s2, input logic po);
    m_bits.delete();
    m_bits.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) m_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    m_bits.push_back((^d) ^ po);
`else
    if (po && 1'b0) m_bits.push_back(1'b0);
`endif
    m_bits.push_back(1'b1);
    if (s2) m_bits.push_back(1'b1);
    m_total    = m_bits.size() * OVS;
    m_n        = 0;
    m_in_frame = 1'b1;
  endfunction

  // Drives one clock cycle, advances the model on the edge and compares all outputs 1 ns later.
  task automatic applyStimulus(input logic rst, input logic tk, input logic st,
                               input logic [DATA_W-1:0] d, input logic s2, input logic po);
    logic exp_tx;
    reset    = rst;
    tick     = tk;
    tx_start = st;
    tx_data  = d;
    stop_2   = s2;
`ifdef UART_TX_PARITY_EN
    parity_odd = po;
`endif
    @(posedge clk);
    if (rst) begin
      m_in_frame = 1'b0;
      m_done     = 1'b0;
    end else if (m_in_frame) begin
      m_done = 1'b0;
      if (tk) begin
        m_n++;
        if (m_n == m_total) begin
          m_in_frame = 1'b0;
          m_done     = 1'b1;
        end
      end
    end else begin
      m_done = 1'b0;
      if (st) modelAccept(d, s2, po);
    end
    exp_tx = m_in_frame ? m_bits[m_n / OVS] : 1'b1;
    #1;
    checkOutput("tx", 32'(tx), 32'(exp_tx));
    checkOutput("busy", 32'(busy), 32'(m_in_frame));
    checkOutput("tx_done", 32'(tx_done), 32'(m_done));
  endtask

  // Runs an accepted frame to completion; busy_cnt includes the accept cycle, done_at is cycles after accept.
  task automatic runFrame(input int period, input bit spam, output int busy_cnt, output int done_at);
    int limit;
    limit    = OVS * 12 * period + 20;
    busy_cnt = 1;
    done_at  = -1;
    for (int k = 1; k <= limit; k++) begin
      applyStimulus(1'b0, (k % period) == 0, spam ? 1'($urandom_range(0, 1)) : 1'b0,
                    DATA_W'($urandom), 1'($urandom), 1'($urandom));
      if (busy) busy_cnt++;
      if (tx_done) begin
        done_at = k;
        break;
      end
    end
    if (done_at < 0) checkOutput("frame_timeout", 32'd0, 32'd1);
  endtask

  function automatic int frameTicks(input bit s2);
    return OVS * (1 + DATA_W + PBITS + (s2 ? 2 : 1));
  endfunction

  initial begin
    int bc;
    int da;
    int per;
    bit s2;
    logic [DATA_W-1:0] d;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, '0, 1'b0, 1'b0);
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);

    $display("[TB] frame 0xA5 one stop bit");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("t1_start_tx", 32'(tx), 32'd0);
    runFrame(1, 1'b0, bc, da);
    checkOutput("t1_done_at", 32'(da), 32'(frameTicks(1'b0)));
    checkOutput("t1_busy_len", 32'(bc), 32'(frameTicks(1'b0)));
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("t1_done_once", 32'(tx_done), 32'd0);

    $display("[TB] frame 0xA5 two stop bits then back-to-back 0x3C");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0);
    runFrame(1, 1'b0, bc, da);
    checkOutput("t2_done_at", 32'(da), 32'(frameTicks(1'b1)));
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1);
    checkOutput("t2_b2b_tx", 32'(tx), 32'd0);
    checkOutput("t2_b2b_busy", 32'(busy), 32'd1);
    runFrame(1, 1'b0, bc, da);
    checkOutput("t2_second_done_at", 32'(da), 32'(frameTicks(1'b0)));

    $display("[TB] tick one cycle in four, start spam while busy");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    runFrame(4, 1'b1, bc, da);
    checkOutput("t3_done_at", 32'(da), 32'(frameTicks(1'b0) * 4));
    checkOutput("t3_busy_len", 32'(bc), 32'(frameTicks(1'b0) * 4));

    $display("[TB] reset mid-frame");
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    for (int k = 0; k < 50; k++) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("t4_reset_tx", 32'(tx), 32'd1);
    checkOutput("t4_reset_busy", 32'(busy), 32'd0);
    checkOutput("t4_reset_done", 32'(tx_done), 32'd0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    runFrame(1, 1'b0, bc, da);
    checkOutput("t4_clean_done_at", 32'(da), 32'(frameTicks(1'b0)));

`ifdef UART_TX_PARITY_EN
    $display("[TB] parity on 0x07");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0);
    runFrame(1, 1'b0, bc, da);
    checkOutput("t5_even_len", 32'(da), 32'd176);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1);
    runFrame(1, 1'b0, bc, da);
    checkOutput("t5_odd_len", 32'(da), 32'd176);
`endif

    $display("[TB] randomized frames");
    for (int f = 0; f < 20; f++) begin
      for (int k = $urandom_range(0, 5); k > 0; k--)
        applyStimulus(1'b0, 1'($urandom), 1'b0, DATA_W'($urandom), 1'($urandom), 1'($urandom));
      d   = DATA_W'($urandom);
      s2  = 1'($urandom);
      per = $urandom_range(1, 3);
      applyStimulus(1'b0, 1'($urandom), 1'b1, d, s2, 1'($urandom));
      runFrame(per, 1'($urandom), bc, da);
      checkOutput("rnd_done_at", 32'(da), 32'(frameTicks(s2) * per));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
